// File: rtl/j6502_clock_reset_gen_pkg.sv
// Shared definitions for the J6502 clock/reset generator: FSM state encoding and
// default timing constants.
package j6502_clock_reset_gen_pkg;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2,
        StStep = 2'd3
    } state_e;

    localparam int unsigned DefDiv       = 8;
    localparam int unsigned DefDead      = 1;
    localparam int unsigned DefResCycles = 2;

endpackage

// File: rtl/j6502_clock_reset_gen.sv
// Two-phase non-overlapping phi1/phi2 generator with stretched CPU reset and
// run/halt/single-step debug control, all timed from fst_clk.
module j6502_clock_reset_gen
    import j6502_clock_reset_gen_pkg::*;
#(
    parameter int unsigned DIV        = DefDiv,
    parameter int unsigned DEAD       = DefDead,
    parameter int unsigned RES_CYCLES = DefResCycles
) (
    input  logic fst_clk,
    input  logic res_n,
    input  logic run,
    input  logic step_req,
    output logic phi1,
    output logic phi2,
    output logic phi2_rise,
    output logic phi2_fall,
    output logic cpu_res_n,
    output logic halted,
    output logic step_ack
);

    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned RW   = $clog2(RES_CYCLES + 1);

    localparam logic [CW-1:0] CntDead   = CW'(DEAD);
    localparam logic [CW-1:0] CntHalfM1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CntPh2    = CW'(HALF + DEAD);
    localparam logic [CW-1:0] CntLast   = CW'(DIV - 1);
    localparam logic [RW-1:0] ResLast   = RW'(RES_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0] res_cnt_q, res_cnt_d;
    logic          cpu_res_d;
    logic          ack_d;

    assign cnt_inc = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        res_cnt_d = res_cnt_q;
        cpu_res_d = cpu_res_n;
        ack_d     = 1'b0;
        unique case (state_q)
            StRst: begin
                // The CPU needs clocks while held in reset, so the phase counter free-runs.
                if (cnt_q == CntLast) begin
                    if (res_cnt_q == ResLast) begin
                        cpu_res_d = 1'b1;
                        state_d   = StRun;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (cnt_q == CntHalfM1 && !run) begin
                    cnt_d   = cnt_q;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (run) begin
                    state_d = StRun;
                end else if (step_req) begin
                    state_d = StStep;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            StStep: begin
                if (cnt_inc == CntHalfM1) begin
                    if (run) begin
                        state_d = StRun;
                    end else begin
                        state_d = StHalt;
                        ack_d   = 1'b1;
                    end
                end
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= StRst;
            cnt_q     <= '0;
            res_cnt_q <= '0;
            cpu_res_n <= 1'b0;
            step_ack  <= 1'b0;
            phi1      <= 1'b0;
            phi2      <= 1'b0;
            phi2_rise <= 1'b0;
            phi2_fall <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_cnt_q <= res_cnt_d;
            cpu_res_n <= cpu_res_d;
            step_ack  <= ack_d;
            // Outputs decode next-cnt so they line up with cnt_q and are glitch-free flops.
            phi1      <= (cnt_d >= CntDead) && (cnt_d <= CntHalfM1);
            phi2      <= (cnt_d >= CntPh2);
            phi2_rise <= (cnt_d == CntPh2);
            phi2_fall <= (cnt_d == CntLast);
        end
    end

    assign halted = (state_q == StHalt);

endmodule
